uart_rx_frontend: RTL

- Serial receive front end that sits directly upstream of the echo/message mode logic.
- Oversamples the raw `rxd` line, rejects glitches, and deframes 8N1 (optionally 8E1) UART characters.
- Presents each good byte on `word` with a one-cycle `word_valid` strobe, which the echo stage consumes.
- Reports line activity and framing errors for status display.

---
 rtl/uart_rx_frontend.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver front end: 2-flop synchronizer, glitch-rejecting start detect, 8N1 deframer.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parity_error strobe.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] word,
  output logic                 word_valid,
  output logic                 word_on_line,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic                 r_sync1;
  logic                 r_rxs;
  state_t               r_state;
  logic [CW-1:0]        r_samp_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_word_valid;
  logic                 r_frame_error;
  logic                 w_samp_half;
  logic                 w_samp_full;

  assign w_samp_half = (r_samp_cnt == C_HALF);
  assign w_samp_full = (r_samp_cnt == C_FULL);

  // Synchronizer resets to the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_pending;
  logic r_parity_error;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_samp_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_pending  <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low every cycle, so any branch that sets one yields a single-cycle pulse.
      r_word_valid  <= 1'b0;
      r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_error <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state    <= S_START;
            r_samp_cnt <= '0;
          end
        end
        S_START: begin
          if (w_samp_half) begin
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= r_rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            r_par_pending <= 1'b0;
`endif
          end else begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_samp_full) begin
            r_samp_cnt <= '0;
            r_shift    <= {r_rxs, r_shift[DATA_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_samp_full) begin
            r_samp_cnt    <= '0;
            r_par_pending <= (^r_shift) ^ r_rxs;
            r_state       <= S_STOP;
          end else begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_samp_full) begin
            r_samp_cnt <= '0;
            if (r_rxs) begin
              r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (r_par_pending) begin
                r_parity_error <= 1'b1;
              end else begin
                r_word       <= r_shift;
                r_word_valid <= 1'b1;
              end
`else
              r_word       <= r_shift;
              r_word_valid <= 1'b1;
`endif
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= S_BREAK;
            end
          end else begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
        // A held-low line parks here so it reports one framing error, not a stream of frames.
        S_BREAK: begin
          if (r_rxs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word         = r_word;
  assign word_valid   = r_word_valid;
  assign word_on_line = (r_state != S_IDLE);
  assign frame_error  = r_frame_error;
`ifdef UART_RX_PARITY_EN
  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

endmodule
